// File: rtl/imem_boot_ctrl.sv
// imem_boot_ctrl
// Boot loader for the instruction memory. Receives a framed byte stream
// (16-bit word count, little-endian instruction words, XOR checksum byte),
// writes each assembled word to the instruction memory and keeps the core
// in reset until a frame has been loaded and verified.

module imem_boot_ctrl #(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic              load_req,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [31:0]       imem_wdata,
  output logic              core_rst,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  localparam logic [2:0] S_HDR_LO = 3'd0;
  localparam logic [2:0] S_HDR_HI = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_CSUM   = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;
  localparam logic [2:0] S_ERROR  = 3'd5;

  // Word count is compared at 17 bits so DEPTH itself is representable.
  localparam logic [16:0] DEPTH_W = 17'(DEPTH);

  // Running checksum update: XOR of every instruction byte.
  function automatic logic [7:0] csum_update(input logic [7:0] acc, input logic [7:0] b);
    csum_update = acc ^ b;
  endfunction

  // Little-endian word assembly: the three earlier bytes sit in the shift
  // register as {b2,b1,b0}; the byte arriving now is b3.
  function automatic logic [31:0] assemble_word(input logic [23:0] low3, input logic [7:0] b3);
    assemble_word = {b3, low3};
  endfunction

  // Load is in progress in these states.
  function automatic logic is_loading(input logic [2:0] st);
    case (st)
      S_HDR_LO, S_HDR_HI, S_DATA, S_CSUM: is_loading = 1'b1;
      default:                            is_loading = 1'b0;
    endcase
  endfunction

  logic [2:0]        state_r;
  logic [2:0]        state_nxt_s;
  logic [15:0]       n_r;
  logic [1:0]        byte_cnt_r;
  logic [23:0]       shift_r;
  logic [7:0]        xor_r;
  logic [ADDR_W:0]   words_loaded_r;
  logic              imem_we_r;
  logic [ADDR_W-1:0] imem_waddr_r;
  logic [31:0]       imem_wdata_r;
  logic              core_rst_r;
  logic              busy_r;
  logic              done_r;
  logic              error_r;

  logic              rx_ready_s;
  logic              accept_s;
  logic [15:0]       n_full_s;
  logic              oversize_s;
  logic              word_done_s;
  logic              last_word_s;
  logic              clear_s;
  logic [ADDR_W:0]   words_next_s;

  // Handshake: ready is a pure state decode, forced low while in reset.
  always_comb begin
    rx_ready_s = is_loading(state_r) & ~rst;
    accept_s   = rx_valid & rx_ready_s;
  end

  // Header decode, word completion and reload qualifiers.
  always_comb begin
    n_full_s     = {rx_data, n_r[7:0]};
    oversize_s   = ({1'b0, n_full_s} > DEPTH_W);
    words_next_s = words_loaded_r + {{ADDR_W{1'b0}}, 1'b1};
    last_word_s  = (16'(words_next_s) == n_r);
    word_done_s  = (state_r == S_DATA) && accept_s && (byte_cnt_r == 2'd3);
    if ((state_r == S_DONE) || (state_r == S_ERROR)) begin
      clear_s = load_req;
    end else begin
      clear_s = 1'b0;
    end
  end

  // Next-state decode for the frame parser.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_HDR_LO: begin
        if (accept_s) begin
          state_nxt_s = S_HDR_HI;
        end else begin
          state_nxt_s = S_HDR_LO;
        end
      end
      S_HDR_HI: begin
        if (!accept_s) begin
          state_nxt_s = S_HDR_HI;
        end else if (oversize_s) begin
          state_nxt_s = S_ERROR;
        end else if (n_full_s == 16'd0) begin
          state_nxt_s = S_CSUM;
        end else begin
          state_nxt_s = S_DATA;
        end
      end
      S_DATA: begin
        if (word_done_s && last_word_s) begin
          state_nxt_s = S_CSUM;
        end else begin
          state_nxt_s = S_DATA;
        end
      end
      S_CSUM: begin
        if (!accept_s) begin
          state_nxt_s = S_CSUM;
        end else if (rx_data == xor_r) begin
          state_nxt_s = S_DONE;
        end else begin
          state_nxt_s = S_ERROR;
        end
      end
      S_DONE, S_ERROR: begin
        if (load_req) begin
          state_nxt_s = S_HDR_LO;
        end else begin
          state_nxt_s = state_r;
        end
      end
      default: begin
        state_nxt_s = S_HDR_LO;
      end
    endcase
  end

  // State register and status flags, all derived from the next state so
  // they change in the same cycle as the state itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= S_HDR_LO;
      core_rst_r <= 1'b1;
      busy_r     <= 1'b1;
      done_r     <= 1'b0;
      error_r    <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      core_rst_r <= (state_nxt_s != S_DONE);
      busy_r     <= is_loading(state_nxt_s);
      done_r     <= (state_nxt_s == S_DONE);
      error_r    <= (state_nxt_s == S_ERROR);
    end
  end

  // Header capture: low byte then high byte of the word count.
  always_ff @(posedge clk) begin
    if (rst) begin
      n_r <= 16'd0;
    end else if (accept_s && (state_r == S_HDR_LO)) begin
      n_r[7:0] <= rx_data;
    end else if (accept_s && (state_r == S_HDR_HI)) begin
      n_r[15:8] <= rx_data;
    end else begin
      n_r <= n_r;
    end
  end

  // Byte assembly and checksum accumulation; cleared on reset and reload so
  // a partial word never survives into the next frame.
  always_ff @(posedge clk) begin
    if (rst || clear_s) begin
      byte_cnt_r <= 2'd0;
      shift_r    <= 24'd0;
      xor_r      <= 8'd0;
    end else if (accept_s && (state_r == S_DATA)) begin
      byte_cnt_r <= byte_cnt_r + 2'd1;
      shift_r    <= {rx_data, shift_r[23:8]};
      xor_r      <= csum_update(xor_r, rx_data);
    end else begin
      byte_cnt_r <= byte_cnt_r;
      shift_r    <= shift_r;
      xor_r      <= xor_r;
    end
  end

  // Instruction memory write port: one-cycle strobe per completed word,
  // address and data held until the next word.
  always_ff @(posedge clk) begin
    if (rst) begin
      imem_we_r    <= 1'b0;
      imem_waddr_r <= {ADDR_W{1'b0}};
      imem_wdata_r <= 32'd0;
    end else if (word_done_s) begin
      imem_we_r    <= 1'b1;
      imem_waddr_r <= words_loaded_r[ADDR_W-1:0];
      imem_wdata_r <= assemble_word(shift_r, rx_data);
    end else begin
      imem_we_r    <= 1'b0;
      imem_waddr_r <= imem_waddr_r;
      imem_wdata_r <= imem_wdata_r;
    end
  end

  // Word counter doubles as the write address of the next word.
  always_ff @(posedge clk) begin
    if (rst || clear_s) begin
      words_loaded_r <= {(ADDR_W+1){1'b0}};
    end else if (word_done_s) begin
      words_loaded_r <= words_next_s;
    end else begin
      words_loaded_r <= words_loaded_r;
    end
  end

  assign rx_ready     = rx_ready_s;
  assign imem_we      = imem_we_r;
  assign imem_waddr   = imem_waddr_r;
  assign imem_wdata   = imem_wdata_r;
  assign core_rst     = core_rst_r;
  assign busy         = busy_r;
  assign done         = done_r;
  assign error        = error_r;
  assign words_loaded = words_loaded_r;

endmodule
